joypad_poller: RTL and testbench
================================

Name: joypad_poller

Overview:
- Host/initiator side of the NES controller serial protocol (latch + clock out, serial data in).
- The hid block emulates the pad (shift-register) side. This block drives one or two real NES/Famicom pads wired to GPIO.
- It polls them periodically and presents parallel, active-high key bytes. These can be merged into the joypad path or the OSD key path.
- Runs in the 21 MHz NES clock domain.

Parameters:
HALF, 126, clock cycles per half bit period (~6 µs @ 21 MHz); must be >= 4
POLL_CYC, 350000, clock cycles between poll starts (~60 Hz); must be > 19*HALF+1

Ports:
I_CLK  in  1  system clock (21 MHz)
I_RESET  in  1  synchronous, active-high reset
I_ENABLE  in  1  permit new poll transactions
I_JOYPAD_DATA1  in  1  serial data from pad 1, active-low, asynchronous
I_JOYPAD_DATA2  in  1  serial data from pad 2, active-low, asynchronous
O_JOYPAD_LATCH  out  1  latch/strobe to both pads, active-high
O_JOYPAD_CLK  out  1  shift clock to both pads, shift on rising edge
O_KEYS1  out  8  pad 1 keys, active-high; bit0..7 = A,B,Select,Start,Up,Down,Left,Right
O_KEYS2  out  8  pad 2 keys, same encoding
O_VALID  out  1  one-cycle pulse when O_KEYS1/O_KEYS2 update

Behaviour:
- Reset: all outputs are 0; the FSM goes to IDLE; the poll counter, shift registers and synchronizers clear. Reset is synchronous, single clock I_CLK, and takes priority over everything including an in-progress transaction.
- Data inputs pass through a 2-flop synchronizer each. All sampling uses the synchronized value. HALF >= 4 guarantees settling.
- Poll counter:
  - Free-runs 0..POLL_CYC-1, then wraps to 0. It is independent of the FSM and of I_ENABLE.
  - Start condition: counter == POLL_CYC-1 && I_ENABLE && state == IDLE. The FSM leaves IDLE on the next cycle.
- FSM states and timing, with H = HALF:
  - IDLE: latch=0, clk=0.
  - LATCH: latch=1 for exactly 2H cycles.
  - GAP: latch=0, clk=0 for H cycles. On the last cycle, sample bit 0 of both pads.
  - CLK_HI(n), n=0..7: clk=1 for H cycles.
  - CLK_LO(n): clk=0 for H cycles. On the last cycle, for n<7, sample bit n+1. For n=7, no sample.
  - DONE: one cycle. O_KEYSx <= ~shift_x, O_VALID=1. Then return to IDLE.
- Every transaction therefore has exactly one latch pulse of 2H cycles and exactly 8 clock pulses of H high/H low. Total length is 19H+1 cycles.
- Bits enter each shift register so that the bit sampled at step n lands in shift[n]. Inversion happens only at DONE.
- Outputs update atomically in DONE only. Between transactions, O_KEYS1/O_KEYS2 hold their last value.
- I_ENABLE deasserted mid-transaction: the transaction completes normally. It only gates new starts.
- Start condition while not IDLE is unreachable because POLL_CYC > 19H+1. If the parameter is violated, the start is ignored; there is no queuing.
- Disconnected pad: input pulled high means all samples are 1, so the keys read 8'h00.
- Reset asserted mid-transaction: latch and clk drop to 0 in the cycle after reset is sampled. Keys clear to 0. No O_VALID pulse.

Test Plan:
- Bench settings: HALF=4, POLL_CYC=200, 4021-style pad models.
- Reset held 5 cycles -> all outputs 0. The first LATCH begins the cycle after the counter hits 199 with I_ENABLE=1.
- Pad1 presses A+Right, pad2 presses Start -> one latch pulse of 8 cycles, exactly 8 clk pulses of 4 high/4 low, O_VALID pulse 77 cycles after latch rise. Then O_KEYS1=8'h81, O_KEYS2=8'h08.
- Both data inputs tied high (no pads) -> O_KEYS1=O_KEYS2=8'h00, O_VALID still pulses once per 200 cycles.
- I_ENABLE=0 across a wrap -> no latch, no clk, no O_VALID, keys hold their previous values. I_ENABLE dropped mid-transaction -> that transaction still completes with a correct O_VALID.
- Reset asserted during CLK_HI(3) -> next cycle latch=0, clk=0, keys=0, no O_VALID. After release, the next poll (counter restarted from 0) yields the correct keys.
- Pad1 pattern changes to all-pressed between polls -> O_KEYS1 goes 8'h81 to 8'hFF only on the second O_VALID, never a partial value in between.

Source files
------------

// File: rtl/joypad_poller.sv
// Host side of the NES/Famicom controller serial protocol: periodically latches
// and clocks out one or two pads and presents their keys as active-high bytes.
module joypad_poller #(
  parameter int HALF     = 126,
  parameter int POLL_CYC = 350000
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_ENABLE,
  input  logic       I_JOYPAD_DATA1,
  input  logic       I_JOYPAD_DATA2,
  output logic       O_JOYPAD_LATCH,
  output logic       O_JOYPAD_CLK,
  output logic [7:0] O_KEYS1,
  output logic [7:0] O_KEYS2,
  output logic       O_VALID
);

  localparam int CNT_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int TMR_W = $clog2(2 * HALF);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(POLL_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_HALF_LAST  = TMR_W'(HALF - 1);
  localparam logic [TMR_W-1:0] TMR_LATCH_LAST = TMR_W'(2 * HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_pollCnt;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_bitIdx;
  logic             r_meta1, r_sync1, r_meta2, r_sync2;
  logic [7:0]       r_shift1, r_shift2;
  logic             r_latch, r_clk, r_valid;
  logic [7:0]       r_keys1, r_keys2;
  logic             w_start, w_lastCyc, w_sample, w_latchNxt, w_clkNxt;

  assign O_JOYPAD_LATCH = r_latch;
  assign O_JOYPAD_CLK   = r_clk;
  assign O_KEYS1        = r_keys1;
  assign O_KEYS2        = r_keys2;
  assign O_VALID        = r_valid;

  assign w_start = (r_pollCnt == CNT_LAST) && I_ENABLE && (r_state == S_IDLE);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_meta1 <= 1'b0;
      r_sync1 <= 1'b0;
      r_meta2 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_meta1 <= I_JOYPAD_DATA1;
      r_sync1 <= r_meta1;
      r_meta2 <= I_JOYPAD_DATA2;
      r_sync2 <= r_meta2;
    end
  end

  // Poll counter free-runs regardless of the FSM or enable.
  always_ff @(posedge I_CLK) begin
    if (I_RESET || (r_pollCnt == CNT_LAST)) r_pollCnt <= '0;
    else                                    r_pollCnt <= r_pollCnt + 1'b1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_lastCyc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_nextState = S_LATCH;
      end
      S_LATCH: begin
        w_lastCyc = (r_tmr == TMR_LATCH_LAST);
        if (w_lastCyc) w_nextState = S_GAP;
      end
      S_GAP: begin
        w_lastCyc = (r_tmr == TMR_HALF_LAST);
        if (w_lastCyc) w_nextState = S_CLK_HI;
      end
      S_CLK_HI: begin
        w_lastCyc = (r_tmr == TMR_HALF_LAST);
        if (w_lastCyc) w_nextState = S_CLK_LO;
      end
      S_CLK_LO: begin
        w_lastCyc = (r_tmr == TMR_HALF_LAST);
        if (w_lastCyc) w_nextState = (r_bitIdx == 3'd7) ? S_DONE : S_CLK_HI;
      end
      S_DONE: begin
        w_lastCyc   = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    w_sample   = w_lastCyc &&
                 ((r_state == S_GAP) || ((r_state == S_CLK_LO) && (r_bitIdx != 3'd7)));
    w_latchNxt = (w_nextState == S_LATCH);
    w_clkNxt   = (w_nextState == S_CLK_HI);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET || (r_state == S_IDLE) || w_lastCyc) r_tmr <= '0;
    else                                             r_tmr <= r_tmr + 1'b1;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET || (r_state == S_IDLE))              r_bitIdx <= 3'd0;
    else if ((r_state == S_CLK_LO) && w_lastCyc)     r_bitIdx <= r_bitIdx + 1'b1;
  end

  // Shifting in from the top leaves the first sample in bit 0 after eight steps.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_shift1 <= 8'h00;
      r_shift2 <= 8'h00;
    end else if (w_sample) begin
      r_shift1 <= {r_sync1, r_shift1[7:1]};
      r_shift2 <= {r_sync2, r_shift2[7:1]};
    end
  end

  // Pad pins are registered so they never glitch on state decode.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_latch <= 1'b0;
      r_clk   <= 1'b0;
      r_valid <= 1'b0;
      r_keys1 <= 8'h00;
      r_keys2 <= 8'h00;
    end else begin
      r_latch <= w_latchNxt;
      r_clk   <= w_clkNxt;
      r_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_keys1 <= ~r_shift1;
        r_keys2 <= ~r_shift2;
      end
    end
  end

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with two 4021-style pad models; each
// scenario task drives its stimulus and checks against hand-derived values.
module tb_joypad_poller;

  localparam int HALF     = 4;
  localparam int POLL_CYC = 200;
  localparam int TXN_LEN  = 19 * HALF + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       data1, data2;
  logic       jpLatch, jpClk, valid;
  logic [7:0] keys1, keys2;

  logic [7:0] press1 = 8'h00;
  logic [7:0] press2 = 8'h00;
  logic       conn1 = 1'b1;
  logic       conn2 = 1'b1;
  logic [7:0] padSr1, padSr2;

  int assertCount = 0;
  int failCount   = 0;

  logic [TXN_LEN-1:0] expLatchW, expClkW, expValidW;

  joypad_poller #(.HALF(HALF), .POLL_CYC(POLL_CYC)) dut (
    .I_CLK          (clk),
    .I_RESET        (reset),
    .I_ENABLE       (enable),
    .I_JOYPAD_DATA1 (data1),
    .I_JOYPAD_DATA2 (data2),
    .O_JOYPAD_LATCH (jpLatch),
    .O_JOYPAD_CLK   (jpClk),
    .O_KEYS1        (keys1),
    .O_KEYS2        (keys2),
    .O_VALID        (valid)
  );

  always #5 clk = ~clk;

  // 4021 model: parallel load while latch is high, shift on rising pad clock.
  always @(posedge jpClk or posedge jpLatch) begin
    if (jpLatch) begin
      padSr1 <= ~press1;
      padSr2 <= ~press2;
    end else begin
      padSr1 <= {1'b1, padSr1[7:1]};
      padSr2 <= {1'b1, padSr2[7:1]};
    end
  end

  assign data1 = conn1 ? padSr1[0] : 1'b1;
  assign data2 = conn2 ? padSr2[0] : 1'b1;

  task automatic waitLatchRise(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!jpLatch && n < limit);
  endtask

  task automatic captureTxn(output logic [TXN_LEN-1:0] lw, output logic [TXN_LEN-1:0] cw,
                            output logic [TXN_LEN-1:0] vw);
    for (int i = 0; i < TXN_LEN; i++) begin
      lw[i] = jpLatch;
      cw[i] = jpClk;
      vw[i] = valid;
      if (i < TXN_LEN - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; enable = 1'b1;
    press1 = 8'h81; press2 = 8'h08;
    repeat (5) @(posedge clk);
    #1;
    assertCount++;
    if ({jpLatch, jpClk, valid, keys1, keys2} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", {jpLatch, jpClk, valid, keys1, keys2}, 19'd0);
    end
    reset = 1'b0;
    waitLatchRise(400, n);
    assertCount++;
    if (!jpLatch || n != POLL_CYC) begin
      failCount++;
      $display("[TB] FAIL first_latch_cycle: got %0d expected %0d", n, POLL_CYC);
    end
  endtask

  task automatic test_basic_poll();
    logic [TXN_LEN-1:0] lw, cw, vw;
    captureTxn(lw, cw, vw);
    assertCount++;
    if (lw !== expLatchW) begin
      failCount++;
      $display("[TB] FAIL latch_wave: got %h expected %h", lw, expLatchW);
    end
    assertCount++;
    if (cw !== expClkW) begin
      failCount++;
      $display("[TB] FAIL clk_wave: got %h expected %h", cw, expClkW);
    end
    assertCount++;
    if (vw !== expValidW) begin
      failCount++;
      $display("[TB] FAIL valid_wave: got %h expected %h", vw, expValidW);
    end
    assertCount++;
    if (keys1 !== 8'h81) begin
      failCount++;
      $display("[TB] FAIL basic_keys1: got %h expected %h", keys1, 8'h81);
    end
    assertCount++;
    if (keys2 !== 8'h08) begin
      failCount++;
      $display("[TB] FAIL basic_keys2: got %h expected %h", keys2, 8'h08);
    end
  endtask

  task automatic test_no_pads();
    logic [TXN_LEN-1:0] lw, cw, vw;
    int n;
    conn1 = 1'b0; conn2 = 1'b0;
    waitLatchRise(250, n);
    assertCount++;
    if (!jpLatch) begin
      failCount++;
      $display("[TB] FAIL nopad_latch_timeout: got %0d expected %0d", jpLatch, 1);
    end
    captureTxn(lw, cw, vw);
    assertCount++;
    if (vw !== expValidW) begin
      failCount++;
      $display("[TB] FAIL nopad_valid_wave: got %h expected %h", vw, expValidW);
    end
    assertCount++;
    if ({keys1, keys2} !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL nopad_keys: got %h expected %h", {keys1, keys2}, 16'h0000);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid && n < 400);
    assertCount++;
    if (!valid || n != POLL_CYC || {keys1, keys2} !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL nopad_valid_period: got %0d keys %h expected %0d keys 0000", n, {keys1, keys2}, POLL_CYC);
    end
    conn1 = 1'b1; conn2 = 1'b1;
  endtask

  task automatic test_enable_gate();
    logic [TXN_LEN-1:0] lw, cw, vw;
    int n, events, keyMoves;
    waitLatchRise(250, n);
    captureTxn(lw, cw, vw);
    assertCount++;
    if ({keys1, keys2} !== 16'h8108) begin
      failCount++;
      $display("[TB] FAIL reconnect_keys: got %h expected %h", {keys1, keys2}, 16'h8108);
    end
    enable = 1'b0;
    events = 0; keyMoves = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (jpLatch || jpClk || valid) events++;
      if ({keys1, keys2} !== 16'h8108) keyMoves++;
    end
    assertCount++;
    if (events != 0) begin
      failCount++;
      $display("[TB] FAIL disabled_activity: got %0d expected %0d", events, 0);
    end
    assertCount++;
    if (keyMoves != 0) begin
      failCount++;
      $display("[TB] FAIL disabled_key_hold: got %0d expected %0d", keyMoves, 0);
    end
    press2 = 8'h30;
    enable = 1'b1;
    waitLatchRise(250, n);
    enable = 1'b0;
    captureTxn(lw, cw, vw);
    assertCount++;
    if (!lw[0] || cw !== expClkW || vw !== expValidW) begin
      failCount++;
      $display("[TB] FAIL drop_enable_txn: got clk %h valid %h expected clk %h valid %h", cw, vw, expClkW, expValidW);
    end
    assertCount++;
    if ({keys1, keys2} !== 16'h8130) begin
      failCount++;
      $display("[TB] FAIL drop_enable_keys: got %h expected %h", {keys1, keys2}, 16'h8130);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_midtxn();
    logic [TXN_LEN-1:0] lw, cw, vw;
    int n, validSeen;
    waitLatchRise(250, n);
    repeat (37) begin
      @(posedge clk); #1;
    end
    assertCount++;
    if ({jpLatch, jpClk} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL clk_hi3_pins: got %b expected %b", {jpLatch, jpClk}, 2'b01);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    assertCount++;
    if ({jpLatch, jpClk, valid, keys1, keys2} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL midtxn_reset_outputs: got %h expected %h", {jpLatch, jpClk, valid, keys1, keys2}, 19'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0; validSeen = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (valid) validSeen++;
    end while (!jpLatch && n < 400);
    assertCount++;
    if (validSeen != 0) begin
      failCount++;
      $display("[TB] FAIL midtxn_stray_valid: got %0d expected %0d", validSeen, 0);
    end
    assertCount++;
    if (!jpLatch || n != POLL_CYC) begin
      failCount++;
      $display("[TB] FAIL post_reset_latch_cycle: got %0d expected %0d", n, POLL_CYC);
    end
    captureTxn(lw, cw, vw);
    assertCount++;
    if (vw !== expValidW || {keys1, keys2} !== 16'h8130) begin
      failCount++;
      $display("[TB] FAIL post_reset_keys: got %h valid %h expected %h valid %h", {keys1, keys2}, vw, 16'h8130, expValidW);
    end
  endtask

  task automatic test_pattern_change();
    int n, partial;
    press1 = 8'hFF;
    n = 0; partial = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!valid && keys1 !== 8'h81) partial++;
    end while (!valid && n < 250);
    assertCount++;
    if (partial != 0) begin
      failCount++;
      $display("[TB] FAIL partial_key_update: got %0d expected %0d", partial, 0);
    end
    assertCount++;
    if (!valid || keys1 !== 8'hFF || keys2 !== 8'h30) begin
      failCount++;
      $display("[TB] FAIL all_pressed_keys: got valid %0d keys %h expected valid 1 keys %h", valid, {keys1, keys2}, 16'hFF30);
    end
  endtask

  initial begin
    for (int i = 0; i < TXN_LEN; i++) begin
      expLatchW[i] = (i < 2 * HALF);
      expClkW[i]   = (i >= 3 * HALF) && (i < 19 * HALF) && (((i - 3 * HALF) % (2 * HALF)) < HALF);
      expValidW[i] = (i == 19 * HALF + 1);
    end
    test_reset();
    test_basic_poll();
    test_no_pads();
    test_enable_gate();
    test_reset_midtxn();
    test_pattern_change();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
